// File: rtl/rcc_reg2ahb.sv
// Register-bus to AHB-Lite master bridge: converts each local req/we/addr/wdata
// transfer into one AHB SINGLE transfer and returns rdata plus a 2-bit response.
module rcc_reg2ahb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int WW      = 4,
  parameter int TIMEOUT = 256
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          req,
  input  logic [WW-1:0] we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    rsp,
  output logic          ready,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [3:0]    hprot,
  output logic [DW-1:0] hwdata,
  input  logic          hready,
  input  logic          hresp,
  input  logic [DW-1:0] hrdata
);

  // state | meaning
  // IDLE  | waiting for req, latches addr/we/wdata
  // CHECK | decodes strobes into hsize and low address bits
  // ADDR  | NONSEQ address phase, held until hready
  // DATA  | data phase, waits for hready/hresp or timeout
  // RESP  | one-cycle ready pulse, back to IDLE
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0]  RSP_OKAY   = 2'b00;
  localparam logic [1:0]  RSP_ERR    = 2'b01;
  localparam logic [1:0]  RSP_TMO    = 2'b10;
  localparam logic [1:0]  RSP_ILL    = 2'b11;
  localparam logic [1:0]  HT_IDLE    = 2'b00;
  localparam logic [1:0]  HT_NONSEQ  = 2'b10;
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  state_t        state_q;
  logic [AW-3:0] addr_q;
  logic [WW-1:0] we_q;
  logic [DW-1:0] wdata_q;
  logic [15:0]   cnt_q;

  logic [DW-1:0] rdata_q;
  logic [1:0]    rsp_q;
  logic          ready_q;
  logic [AW-1:0] haddr_q;
  logic [1:0]    htrans_q;
  logic          hwrite_q;
  logic [2:0]    hsize_q;
  logic [DW-1:0] hwdata_q;

  logic          legal_d;
  logic [2:0]    size_d;
  logic [1:0]    lo_d;

  always_comb begin
    legal_d = 1'b1;
    size_d  = 3'b010;
    lo_d    = 2'b00;
    case (we_q)
      4'b0000, 4'b1111: begin size_d = 3'b010; lo_d = 2'b00; end
      4'b0011:          begin size_d = 3'b001; lo_d = 2'b00; end
      4'b1100:          begin size_d = 3'b001; lo_d = 2'b10; end
      4'b0001:          begin size_d = 3'b000; lo_d = 2'b00; end
      4'b0010:          begin size_d = 3'b000; lo_d = 2'b01; end
      4'b0100:          begin size_d = 3'b000; lo_d = 2'b10; end
      4'b1000:          begin size_d = 3'b000; lo_d = 2'b11; end
      default:          legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rsp_q    <= RSP_OKAY;
      ready_q  <= 1'b0;
      haddr_q  <= '0;
      htrans_q <= HT_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b010;
      hwdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr[AW-1:2];
            we_q    <= we;
            wdata_q <= wdata;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (legal_d) begin
            haddr_q  <= {addr_q, lo_d};
            hsize_q  <= size_d;
            hwrite_q <= (we_q != '0);
            hwdata_q <= (we_q != '0) ? wdata_q : '0;
            htrans_q <= HT_NONSEQ;
            state_q  <= S_ADDR;
          end else begin
            rsp_q   <= RSP_ILL;
            rdata_q <= '0;
            ready_q <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_ADDR: begin
          if (hready) begin
            htrans_q <= HT_IDLE;
            cnt_q    <= '0;
            state_q  <= S_DATA;
          end
        end
        S_DATA: begin
          // an error on its first (hready=0) cycle is taken at once; the
          // trailing hready=1 cycle then lands in RESP and is ignored
          if (hresp) begin
            rsp_q   <= RSP_ERR;
            rdata_q <= '0;
            ready_q <= 1'b1;
            state_q <= S_RESP;
          end else if (hready) begin
            rsp_q   <= RSP_OKAY;
            rdata_q <= hwrite_q ? '0 : hrdata;
            ready_q <= 1'b1;
            state_q <= S_RESP;
          end else if (cnt_q == TMO_LAST) begin
            rsp_q   <= RSP_TMO;
            rdata_q <= '0;
            ready_q <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RESP: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rsp    = rsp_q;
  assign ready  = ready_q;
  assign haddr  = haddr_q;
  assign htrans = htrans_q;
  assign hwrite = hwrite_q;
  assign hsize  = hsize_q;
  assign hwdata = hwdata_q;
  assign hburst = 3'b000;
  assign hprot  = 4'b0011;

endmodule

// File: tb/tb_rcc_reg2ahb.sv
// Directed bench for rcc_reg2ahb: drives single transfers against a scripted
// AHB slave and compares against hand-computed expectations.
module tb_rcc_reg2ahb;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        req;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  rsp;
  logic        ready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  rcc_reg2ahb #(.AW(32), .DW(32), .WW(4), .TIMEOUT(8)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rsp    (rsp),
    .ready  (ready),
    .haddr  (haddr),
    .htrans (htrans),
    .hwrite (hwrite),
    .hsize  (hsize),
    .hburst (hburst),
    .hprot  (hprot),
    .hwdata (hwdata),
    .hready (hready),
    .hresp  (hresp),
    .hrdata (hrdata)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int          t_cycles;
  int          t_pulses;
  int          t_nonseq;
  int          t_hwbad;
  int          t_htbad;
  logic [31:0] t_haddr;
  logic [2:0]  t_hsize;
  logic        t_hwrite;
  logic [31:0] t_rdata;
  logic [1:0]  t_rsp;

  // mode 0: normal with `waits` wait states, 1: two-cycle error, 2: slave hangs
  task automatic xfer(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input int mode, input logic [31:0] rd);
    int cyc;
    int dcnt;
    int post;
    bit aseen;
    bit indata;
    cyc = 0; dcnt = 0; post = 0; aseen = 0; indata = 0;
    t_cycles = -1; t_pulses = 0; t_nonseq = 0; t_hwbad = 0; t_htbad = 0;
    t_haddr = '0; t_hsize = '0; t_hwrite = 1'b0; t_rdata = '0; t_rsp = '0;
    @(negedge hclk);
    req = 1'b1; we = s; addr = a; wdata = d;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'hA5A5_A5A5;
    while (post < 3 && cyc < 60) begin
      @(posedge hclk);
      cyc++;
      @(negedge hclk);
      if (cyc == 1) begin
        we = ~s; addr = ~a; wdata = ~d;
      end
      if (ready) begin
        t_pulses++;
        if (t_cycles < 0) begin
          t_cycles = cyc; t_rdata = rdata; t_rsp = rsp;
        end
        req = 1'b0;
        if (!(mode == 1 && dcnt == 1)) indata = 0;
      end
      if (t_cycles >= 0) post++;
      if (htrans == 2'b10) begin
        t_nonseq++; t_haddr = haddr; t_hsize = hsize; t_hwrite = hwrite; aseen = 1;
      end else if (htrans != 2'b00) begin
        t_htbad++;
      end else if (aseen) begin
        aseen = 0; indata = 1; dcnt = 0;
      end
      if (indata) begin
        if (hwdata !== ((s == 4'b0000) ? 32'h0 : d)) t_hwbad++;
        case (mode)
          0: begin
            hready = (dcnt >= waits); hresp = 1'b0;
            hrdata = (dcnt >= waits) ? rd : 32'hBAD0_0000;
          end
          1: begin
            hready = (dcnt != 0); hresp = (dcnt < 2); hrdata = rd;
            if (dcnt >= 2) indata = 0;
          end
          default: begin
            hready = 1'b0; hresp = 1'b0; hrdata = rd;
          end
        endcase
        dcnt++;
      end else begin
        hready = 1'b1; hresp = 1'b0; hrdata = 32'hA5A5_A5A5;
      end
    end
    req = 1'b0;
    hready = 1'b1; hresp = 1'b0;
  endtask

  int rst_ready;

  initial begin
    hreset = 1'b1; req = 1'b0; we = '0; addr = '0; wdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_ready",  {31'd0, ready}, 32'd0);
    check("rst_rsp",    {30'd0, rsp},   32'd0);
    check("rst_rdata",  rdata,          32'd0);
    check("rst_htrans", {30'd0, htrans}, 32'd0);
    check("rst_haddr",  haddr,          32'd0);
    check("rst_hwrite", {31'd0, hwrite}, 32'd0);
    check("rst_hsize",  {29'd0, hsize}, 32'd2);
    check("rst_hwdata", hwdata,         32'd0);
    check("hburst",     {29'd0, hburst}, 32'd0);
    check("hprot",      {28'd0, hprot}, 32'd3);
    hreset = 1'b0;

    // word write, zero wait
    xfer(4'b1111, 32'h4000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0);
    check("ww_cycles", t_cycles, 4);
    check("ww_nonseq", t_nonseq, 1);
    check("ww_haddr",  t_haddr, 32'h4000_0010);
    check("ww_hsize",  {29'd0, t_hsize}, 32'd2);
    check("ww_hwrite", {31'd0, t_hwrite}, 32'd1);
    check("ww_hwdata", t_hwbad, 0);
    check("ww_rsp",    {30'd0, t_rsp}, 32'd0);
    check("ww_rdata",  t_rdata, 32'd0);
    check("ww_pulses", t_pulses, 1);

    // read with 3 wait states
    xfer(4'b0000, 32'h0000_0014, 32'h0, 3, 0, 32'h1234_5678);
    check("rd_cycles", t_cycles, 7);
    check("rd_rdata",  t_rdata, 32'h1234_5678);
    check("rd_rsp",    {30'd0, t_rsp}, 32'd0);
    check("rd_haddr",  t_haddr, 32'h0000_0014);
    check("rd_hwrite", {31'd0, t_hwrite}, 32'd0);
    check("rd_hsize",  {29'd0, t_hsize}, 32'd2);
    check("rd_hold",   rdata, 32'h1234_5678);

    // AHB error on a read: two-cycle hresp
    xfer(4'b0000, 32'h0000_0030, 32'h0, 0, 1, 32'h7777_7777);
    check("er_rsp",    {30'd0, t_rsp}, 32'd1);
    check("er_rdata",  t_rdata, 32'd0);
    check("er_pulses", t_pulses, 1);
    check("er_cycles", t_cycles, 4);
    check("er_nonseq", t_nonseq, 1);
    check("er_htrans", t_htbad, 0);

    // byte / half / illegal strobes
    xfer(4'b0100, 32'h0000_0020, 32'h00AB_0000, 0, 0, 32'h0);
    check("b2_haddr",  t_haddr, 32'h0000_0022);
    check("b2_hsize",  {29'd0, t_hsize}, 32'd0);
    check("b2_cycles", t_cycles, 4);
    xfer(4'b1100, 32'h0000_0020, 32'hABCD_0000, 0, 0, 32'h0);
    check("h1_haddr",  t_haddr, 32'h0000_0022);
    check("h1_hsize",  {29'd0, t_hsize}, 32'd1);
    xfer(4'b0011, 32'h0000_0023, 32'h0000_1234, 0, 0, 32'h0);
    check("h0_haddr",  t_haddr, 32'h0000_0020);
    xfer(4'b1000, 32'h0000_0020, 32'hEE00_0000, 0, 0, 32'h0);
    check("b3_haddr",  t_haddr, 32'h0000_0023);
    check("b3_hsize",  {29'd0, t_hsize}, 32'd0);
    xfer(4'b0010, 32'h0000_0020, 32'h0000_5500, 0, 0, 32'h0);
    check("b1_haddr",  t_haddr, 32'h0000_0021);
    xfer(4'b0101, 32'h0000_0020, 32'h1111_1111, 0, 0, 32'h0);
    check("il_rsp",    {30'd0, t_rsp}, 32'd3);
    check("il_cycles", t_cycles, 2);
    check("il_nonseq", t_nonseq, 0);
    check("il_pulses", t_pulses, 1);

    // timeout with TIMEOUT=8, then a normal read
    xfer(4'b0000, 32'h0000_0050, 32'h0, 0, 2, 32'h0);
    check("to_rsp",    {30'd0, t_rsp}, 32'd2);
    check("to_cycles", t_cycles, 11);
    check("to_pulses", t_pulses, 1);
    check("to_nonseq", t_nonseq, 1);
    xfer(4'b0000, 32'h0000_0054, 32'h0, 0, 0, 32'h0BAD_F00D);
    check("ar_cycles", t_cycles, 4);
    check("ar_rdata",  t_rdata, 32'h0BAD_F00D);
    check("ar_rsp",    {30'd0, t_rsp}, 32'd0);

    // reset while in the data phase
    @(negedge hclk);
    req = 1'b1; we = 4'b1111; addr = 32'h0000_0040; wdata = 32'hCAFE_0001; hready = 1'b1;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    req = 1'b0; hready = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    check("mr_htrans", {30'd0, htrans}, 32'd0);
    check("mr_ready",  {31'd0, ready}, 32'd0);
    check("mr_rdata",  rdata, 32'd0);
    check("mr_hsize",  {29'd0, hsize}, 32'd2);
    check("mr_haddr",  haddr, 32'd0);
    check("mr_hwdata", hwdata, 32'd0);
    hreset = 1'b0; hready = 1'b1;
    rst_ready = 0;
    repeat (12) begin
      @(posedge hclk);
      @(negedge hclk);
      if (ready) rst_ready++;
    end
    check("mr_noready", rst_ready, 0);
    xfer(4'b1111, 32'h0000_0044, 32'h1357_9BDF, 0, 0, 32'h0);
    check("mr_cycles", t_cycles, 4);
    check("mr_rsp",    {30'd0, t_rsp}, 32'd0);
    check("mr_haddr2", t_haddr, 32'h0000_0044);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
